// File: rtl/uart_hex_printer.sv
// uart_hex_printer: captures a binary value on request and streams its ASCII
// hex form ("0x" prefix, MSB-first digits, CR LF) into a UART TX enqueue port.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   req      - print request, sampled only while busy=0
//   value    - value to print, captured on the accepted req cycle
//   busy     - high from the cycle after acceptance through the done cycle
//   done     - one-cycle pulse after the last byte has been enqueued
//   tx_start - one-cycle enqueue strobe per byte
//   tx_data  - byte qualified by tx_start (holds its last value otherwise)
//   tx_ready - transmitter FIFO can accept a byte (registered, one cycle late)
module uart_hex_printer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PREFIX_EN  = 1'b1,
    parameter bit          NEWLINE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  done,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);

    localparam int unsigned N     = DATA_WIDTH / 4;
    localparam int unsigned CW    = $clog2(N) + 1;
    localparam int unsigned NSLOT = 1 << CW;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PFX0  = 3'd1,
        S_PFX1  = 3'd2,
        S_DIGIT = 3'd3,
        S_CR    = 3'd4,
        S_LF    = 3'd5,
        S_GAP   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t                state_q, state_d;
    state_t                ret_q, ret_d;      // emit state to resume after GAP
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;

    logic                  busy_d, done_d, tx_start_d;
    logic [7:0]            tx_data_d;

    // Nibble table indexed by the digit counter; padded to a power of two so
    // every counter value addresses a defined slot.
    logic [3:0] nib_slot [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < N) begin : g_used
            assign nib_slot[k] = cap_q[DATA_WIDTH-1-4*k -: 4];
        end else begin : g_pad
            assign nib_slot[k] = 4'h0;
        end
    end

    logic [3:0] nib_c;
    logic [7:0] digit_ascii_c;
    logic [7:0] byte_c;
    logic       push_c;

    assign nib_c         = nib_slot[cnt_q];
    assign digit_ascii_c = (nib_c <= 4'd9) ? (8'h30 + 8'(nib_c))
                                           : (8'h41 + 8'(nib_c - 4'd10));

    // State and datapath registers, plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            cnt_q    <= '0;
            cap_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            busy     <= busy_d;
            done     <= done_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        unique case (state_q)
            S_IDLE: begin
                // busy is still high during the done cycle, which blocks re-accept
                if (req && !busy) begin
                    cap_d   = value;
                    cnt_d   = '0;
                    state_d = PREFIX_EN ? S_PFX0 : S_DIGIT;
                end
            end
            S_PFX0: begin
                if (tx_ready) begin
                    state_d = S_GAP;
                    ret_d   = S_PFX1;
                end
            end
            S_PFX1: begin
                if (tx_ready) begin
                    state_d = S_GAP;
                    ret_d   = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (tx_ready) begin
                    state_d = S_GAP;
                    if (cnt_q == LAST_DIGIT) begin
                        ret_d = NEWLINE_EN ? S_CR : S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        ret_d = S_DIGIT;
                    end
                end
            end
            S_CR: begin
                if (tx_ready) begin
                    state_d = S_GAP;
                    ret_d   = S_LF;
                end
            end
            S_LF: begin
                if (tx_ready) begin
                    state_d = S_GAP;
                    ret_d   = S_DONE;
                end
            end
            S_GAP:   state_d = ret_q;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers on the next edge.
    always_comb begin
        push_c = 1'b0;
        byte_c = 8'h00;
        unique case (state_q)
            S_PFX0:  begin push_c = tx_ready; byte_c = 8'h30;         end
            S_PFX1:  begin push_c = tx_ready; byte_c = 8'h78;         end
            S_DIGIT: begin push_c = tx_ready; byte_c = digit_ascii_c; end
            S_CR:    begin push_c = tx_ready; byte_c = 8'h0D;         end
            S_LF:    begin push_c = tx_ready; byte_c = 8'h0A;         end
            default: begin push_c = 1'b0;     byte_c = 8'h00;         end
        endcase

        tx_start_d = push_c;
        tx_data_d  = push_c ? byte_c : tx_data;
        done_d     = (state_q == S_DONE);
        // Keep busy high through the cycle in which done is visible.
        busy_d     = (state_d != S_IDLE) || (state_q == S_DONE);
    end

endmodule

// File: doc/uart_hex_printer.md
Name: uart_hex_printer

Overview:
Upstream feeder for the UART transmit FIFO. Captures a binary value on request and streams its ASCII hex representation byte by byte into the transmitter's enqueue interface. The output string is optional "0x", then the digits MSB-first, then optional CR LF. Used for debug and status printing from any logic in the design without hand-building byte sequences.

Parameters:
DATA_WIDTH, 32, width of value; must be a multiple of 4 (min 4); digit count N = DATA_WIDTH/4
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits
NEWLINE_EN, 1, 1 = emit CR LF (0x0D, 0x0A) after the digits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  1  print request; sampled only while busy=0
value  input  DATA_WIDTH  value to print; captured on the accepted req cycle
busy  output  1  high from the cycle after req is accepted until the done cycle inclusive
done  output  1  single-cycle pulse after the last byte is enqueued
tx_start  output  1  enqueue strobe to the UART transmitter (one-cycle pulse per byte)
tx_data  output  8  byte presented with tx_start
tx_ready  input  1  transmitter FIFO can accept a byte (registered; lags the FIFO by one cycle)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, tx_start=0, tx_data=0x00, capture register=0, digit counter=0. Any in-progress message is abandoned with no further bytes; the next req after release starts cleanly.
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF, GAP, DONE.
- IDLE: if req=1, capture value, clear digit counter, set busy=1, and go to PFX0 (PREFIX_EN=1) or DIGIT (PREFIX_EN=0). req while busy=1 is ignored (not queued).
- Emit states (PFX0, PFX1, DIGIT, CR, LF): if tx_ready=1, assert tx_start for exactly one cycle with tx_data, then go to GAP. If tx_ready=0, hold the state with tx_start=0.
- GAP: mandatory one idle cycle after every push (tx_start=0). This lets tx_ready reflect the push before it is sampled again. Then advance to the next emit state.
- Byte order: PFX0 0x30, PFX1 0x78; DIGIT sends nibble [DATA_WIDTH-1-4k -: 4] for k=0..N-1; CR 0x0D; LF 0x0A. After the last digit: CR if NEWLINE_EN=1, else DONE.
- Nibble-to-ASCII: n<=9 gives 0x30+n; n>=10 gives 0x41+(n-10) (uppercase A-F). Use 8-bit arithmetic with no overflow.
- Digit counter width is clog2(N)+1. DIGIT exits when counter==N-1 after a push.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE with busy=0. A req in the DONE cycle is ignored. The earliest next accept is the following cycle.
- Throughput: at most one push per 2 cycles. With tx_ready held at 1, for M bytes:
  - first tx_start occurs 1 cycle after the req-accept edge;
  - last push is at first push + 2(M-1);
  - done comes 2 cycles after the last push (GAP, DONE).
- tx_data holds its last value when tx_start=0. Consumers only qualify tx_data with tx_start.
- The captured value is held for the whole message; changes on value after acceptance have no effect.

Test Plan:
- Defaults, value=0xDEADBEEF, tx_ready=1 -> tx_start bytes exactly 30 78 44 45 41 44 42 45 45 46 0D 0A; 12 pulses spaced 2 cycles apart; one done pulse; busy deasserts the cycle after done.
- tx_ready=0 for 10 cycles before the 4th byte -> tx_start stays low throughout, then byte 0x45 is sent once with no duplication or skip; total sequence is unchanged.
- req pulsed again mid-message with value=0x12345678 -> ignored; output stays the 0xDEADBEEF string; a new req after done prints "0x12345678\r\n".
- rst_n asserted after the 5th byte -> tx_start=0, busy=0, done=0 immediately (async); after release, req value=0x0000000A gives 30 78 30 30 30 30 30 30 30 41 0D 0A.
- DATA_WIDTH=8, PREFIX_EN=0, NEWLINE_EN=0, value=0x9F -> exactly two bytes 39 46, then done; value=0x00 gives 30 30.
- Connected to the UART transmitter (27 MHz, 115200) with 3 back-to-back 32-bit prints -> serial line decodes all 36 bytes in order with no FIFO drop.
